// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer.
// It decodes three word registers: CTRL, PRESET and COUNT.
// It supports one-shot and auto-reload modes and drives a maskable interrupt line.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, Mode[1:0], Enable}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic        ctrl_we;
    logic        preset_we;
    logic        enable;
    logic        auto_reload;
    logic        unused_addr;

    // The bridge has already qualified the window, so only the word offset matters.
    assign unused_addr = ^Addr[31:4];
    assign ctrl_we     = WE && (Addr[3:2] == 2'd0);
    assign preset_we   = WE && (Addr[3:2] == 2'd1);
    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'd1);

    // Register state, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Next-state: FSM sequencing, then bus writes layered with their priorities
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        // A CTRL write clears the flag; a terminal-count set below overrides it.
        if (ctrl_we) begin
            irq_d = 1'b0;
        end
        if (preset_we) begin
            preset_d = Din;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    irq_d   = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                if (auto_reload) begin
                    irq_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Applied last so a written value beats the one-shot Enable clear.
        if (ctrl_we) begin
            ctrl_d = Din[3:0];
        end
    end

    // Zero-latency read mux
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = '0;
        endcase
    end

    assign IRQ = irq_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed vector tables plus randomized
// bus traffic checked against a cycle-level reference model.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int unsigned n_cmp;
    int unsigned n_bad;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    // Reference model of the programmer-visible timer
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_FIRE} mphase_t;
    mphase_t     m_ph;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;

    task automatic model_reset();
        m_ph = M_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [3:0]  c;
        logic [31:0] p;
        logic [31:0] n;
        logic        f;
        logic        fired;
        mphase_t     ph;
        c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_ph; fired = 1'b0;
        case (m_ph)
            M_IDLE: if (m_ctrl[0]) ph = M_LOAD;
            M_LOAD: begin n = m_preset; ph = M_RUN; end
            M_RUN: begin
                if (!m_ctrl[0]) ph = M_IDLE;
                else if (m_count > 1) n = m_count - 1;
                else begin n = 0; fired = 1'b1; ph = M_FIRE; end
            end
            M_FIRE: begin
                ph = M_IDLE;
                if (m_ctrl[2:1] == 2'd1) f = 1'b0;
                else c[0] = 1'b0;
            end
            default: ph = M_IDLE;
        endcase
        if (we && a == 2'd0) c = d[3:0];
        if (we && a == 2'd1) p = d;
        if (fired) f = 1'b1;
        else if (we && a == 2'd0) f = 1'b0;
        m_ph = ph; m_ctrl = c; m_preset = p; m_count = n; m_flag = f;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] ba;
        ba   = 32'h0000_7F00 | {28'd0, a, 2'b00};
        Addr = ba[31:2];
        WE   = we;
        Din  = d;
    endtask

    // One bus cycle: drive, clock, then sample after the edge
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input string nm, input logic [31:0] exp_dout, input logic exp_irq);
        drive(we, a, d);
        @(posedge clk);
        #1;
        check({nm, ".dout"}, Dout, exp_dout);
        check({nm, ".irq"}, {31'd0, IRQ}, {31'd0, exp_irq});
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_table(input string nm);
        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].adr, tbl[i].din, $sformatf("%s[%0d]", nm, i),
                 tbl[i].exp_dout, tbl[i].exp_irq);
        end
        tbl.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        drive(1'b0, 2'd0, 32'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset state: every offset reads zero, no interrupt
        for (int i = 0; i < 4; i++) tbl.push_back(vec_t'{1'b0, 2'(i), 32'd0, 32'd0, 1'b0});
        run_table("reset");

        // One-shot, P=3, CTRL=0x9 at edge 0
        tbl.push_back(vec_t'{1'b1, 2'd1, 32'd3,          32'd3, 1'b0});
        tbl.push_back(vec_t'{1'b1, 2'd0, 32'hFFFF_FFF9,  32'h9, 1'b0}); // edge 0
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd0, 1'b0}); // edge 1 (LOAD)
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd3, 1'b0}); // edge 2
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd2, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd0, 1'b1}); // edge 5
        tbl.push_back(vec_t'{1'b0, 2'd0, 32'd0,          32'h8, 1'b1}); // edge 6
        tbl.push_back(vec_t'{1'b0, 2'd2, 32'd0,          32'd0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 2'd0, 32'h8,          32'h8, 1'b0}); // CTRL write clears
        tbl.push_back(vec_t'{1'b0, 2'd0, 32'd0,          32'h8, 1'b0});
        run_table("oneshot");

        // Auto-reload, P=2: pulses after edges 4, 9, 14
        do_reset();
        step(1'b1, 2'd1, 32'd2, "ar.pre", 32'd2, 1'b0);
        step(1'b1, 2'd0, 32'hB, "ar.ctrl", 32'hB, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            step(1'b0, 2'd0, 32'd0, $sformatf("ar.e%0d", e), 32'hB,
                 (e == 4 || e == 9 || e == 14));
        end

        // Same with IM=0, then IM set mid-run keeps the schedule
        do_reset();
        step(1'b1, 2'd1, 32'd2, "nm.pre", 32'd2, 1'b0);
        step(1'b1, 2'd0, 32'h3, "nm.ctrl", 32'h3, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e1", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e2", 32'd2, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e3", 32'd1, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e4", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e5", 32'd0, 1'b0);
        step(1'b1, 2'd0, 32'hB, "nm.e6", 32'hB, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e7", 32'd2, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e8", 32'd1, 1'b0);
        step(1'b0, 2'd2, 32'd0, "nm.e9", 32'd0, 1'b1);
        step(1'b0, 2'd2, 32'd0, "nm.e10", 32'd0, 1'b0);

        // Disable mid-count freezes COUNT; COUNT/unused writes ignored
        do_reset();
        step(1'b1, 2'd1, 32'd10, "fz.pre", 32'd10, 1'b0);
        step(1'b1, 2'd0, 32'h1, "fz.ctrl", 32'h1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 2'd2, 32'd0, $sformatf("fz.e%0d", e),
                 (e == 1) ? 32'd0 : 32'(12 - e), 1'b0);
        end
        step(1'b1, 2'd0, 32'h0, "fz.off", 32'h0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "fz.hold1", 32'd5, 1'b0);
        step(1'b0, 2'd2, 32'd0, "fz.hold2", 32'd5, 1'b0);
        step(1'b1, 2'd2, 32'hFFFF, "fz.wcount", 32'd5, 1'b0);
        step(1'b1, 2'd3, 32'hFFFF, "fz.wunused", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "fz.hold3", 32'd5, 1'b0);

        // Reset mid-count aborts; then P=0 fires at edge 3
        do_reset();
        step(1'b1, 2'd1, 32'd4, "rs.pre", 32'd4, 1'b0);
        step(1'b1, 2'd0, 32'h9, "rs.ctrl", 32'h9, 1'b0);
        step(1'b0, 2'd2, 32'd0, "rs.e1", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "rs.e2", 32'd4, 1'b0);
        step(1'b0, 2'd2, 32'd0, "rs.e3", 32'd3, 1'b0);
        step(1'b0, 2'd2, 32'd0, "rs.e4", 32'd2, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 32'd0, $sformatf("rs.rd%0d", i), 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd2, 32'd0, $sformatf("rs.idle%0d", i), 32'd0, 1'b0);
        step(1'b1, 2'd0, 32'h9, "p0.ctrl", 32'h9, 1'b0);
        step(1'b0, 2'd2, 32'd0, "p0.e1", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "p0.e2", 32'd0, 1'b0);
        step(1'b0, 2'd2, 32'd0, "p0.e3", 32'd0, 1'b1);
        step(1'b0, 2'd0, 32'd0, "p0.e4", 32'h8, 1'b1);

        // Randomized bus traffic against the reference model
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            int unsigned op;
            logic        we;
            logic [1:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 19);
            we = 1'b0;
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            if (op == 0) begin
                we = 1'b1; a = 2'd0;
                d[0] = ($urandom_range(0, 9) < 7);
            end else if (op == 1) begin
                we = 1'b1; a = 2'd1; d = 32'($urandom_range(0, 6));
            end else if (op == 2) begin
                we = 1'b1; a = 2'($urandom_range(2, 3));
            end
            model_edge(we, a, d);
            step(we, a, d, $sformatf("rnd%0d", k), model_read(a), m_flag & m_ctrl[3]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
